// File: rtl/tjmono_readout_emu.sv
// tjmono_readout_emu
//   Chip-side emulator of the TJ-Monopix column readout (TOK/FREEZE/READ/OUT).
//   Hits are queued into a FIFO, announced on TOK_OUT, and shifted out MSB-first
//   on DATA_OUT after a READ_IN pulse.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   HIT_WR/HIT_DATA push a hit word; HIT_FULL flags a full FIFO (writes dropped)
//   FREEZE_IN       freeze from receiver; snapshots the occupancy on its rising edge
//   READ_IN         one-cycle read request from receiver
//   TOK_OUT         registered token: words available (snapshot while frozen)
//   DATA_OUT        serial hit data, MSB first
//   BUSY            shift in progress
//   OCCUPANCY       words currently in the FIFO
//   ERR_CNT         saturating protocol error count
//
// Configuration
//   TJMONO_EMU_PARITY_EN  append one even-parity bit (XOR of the word) after bit 0

module tjmono_readout_emu #(
  parameter int unsigned FIFO_ADDR_BITS = 4,
  parameter int unsigned WORD_BITS      = 27
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      HIT_WR,
  input  logic [WORD_BITS-1:0]      HIT_DATA,
  output logic                      HIT_FULL,
  input  logic                      FREEZE_IN,
  input  logic                      READ_IN,
  output logic                      TOK_OUT,
  output logic                      DATA_OUT,
  output logic                      BUSY,
  output logic [FIFO_ADDR_BITS:0]   OCCUPANCY,
  output logic [7:0]                ERR_CNT
);

  localparam int unsigned DEPTH = 2 ** FIFO_ADDR_BITS;
`ifdef TJMONO_EMU_PARITY_EN
  localparam int unsigned SHIFT_LEN = WORD_BITS + 1;
`else
  localparam int unsigned SHIFT_LEN = WORD_BITS;
`endif
  localparam int unsigned CNT_W = $clog2(SHIFT_LEN);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                    state_q;
  logic [WORD_BITS-1:0]      mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q;
  logic [FIFO_ADDR_BITS-1:0] rd_ptr_q;
  logic [FIFO_ADDR_BITS:0]   occ_q;
  logic [FIFO_ADDR_BITS:0]   snap_q;
  logic                      freeze_q;
  logic [SHIFT_LEN-1:0]      shreg_q;
  logic [CNT_W-1:0]          cnt_q;

  logic                      full;
  logic                      avail;
  logic                      wr_acc;
  logic                      pop;
  logic                      err_ev;
  logic [WORD_BITS-1:0]      head;
  logic [SHIFT_LEN-1:0]      load_word;

  always_comb begin
    full   = (occ_q == (FIFO_ADDR_BITS + 1)'(DEPTH));
    // While frozen only the words present at the freeze edge may be read.
    avail  = FREEZE_IN ? (snap_q != '0) : (occ_q != '0);
    // Fullness is judged on the pre-edge occupancy: a same-cycle pop frees nothing.
    wr_acc = HIT_WR && !full;
    pop    = READ_IN && (state_q == StIdle) && avail;
    err_ev = (READ_IN && (state_q == StShift)) ||
             (READ_IN && (state_q == StIdle) && !avail) ||
             (HIT_WR && full);
    head   = mem[rd_ptr_q];
`ifdef TJMONO_EMU_PARITY_EN
    load_word = {head, ^head};
`else
    load_word = head;
`endif
  end

  assign HIT_FULL  = full;
  assign OCCUPANCY = occ_q;

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= HIT_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      snap_q   <= '0;
      freeze_q <= 1'b0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      TOK_OUT  <= 1'b0;
      DATA_OUT <= 1'b0;
      BUSY     <= 1'b0;
      ERR_CNT  <= 8'd0;
    end else begin
      freeze_q <= FREEZE_IN;
      TOK_OUT  <= FREEZE_IN ? (snap_q != '0) : (occ_q != '0);

      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;

      unique case ({wr_acc, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase

      // Snapshot excludes a write landing in the same cycle as the freeze edge.
      if (!FREEZE_IN) begin
        snap_q <= '0;
      end else if (!freeze_q) begin
        snap_q <= occ_q;
      end else if (pop) begin
        snap_q <= snap_q - 1'b1;
      end

      if (err_ev && (ERR_CNT != 8'hFF)) begin
        ERR_CNT <= ERR_CNT + 8'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q  <= StShift;
            DATA_OUT <= load_word[SHIFT_LEN-1];
            shreg_q  <= load_word << 1;
            cnt_q    <= CNT_W'(SHIFT_LEN - 1);
            BUSY     <= 1'b1;
          end else begin
            DATA_OUT <= 1'b0;
            BUSY     <= 1'b0;
          end
        end
        StShift: begin
          if (cnt_q == '0) begin
            state_q  <= StIdle;
            DATA_OUT <= 1'b0;
            BUSY     <= 1'b0;
          end else begin
            DATA_OUT <= shreg_q[SHIFT_LEN-1];
            shreg_q  <= shreg_q << 1;
            cnt_q    <= cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

endmodule
